corr_search_ctrl: RTL and testbench
===================================

# corr_search_ctrl

Sequences the correlation scorer over a rectangular grid of candidate start positions and reports the best-matching position. For each candidate it presents start coordinates, launches one correlation, waits for the scorer's finished flag, captures the 32-bit score and keeps a running maximum. It sits between the frame/search logic, which issues `iStart`, and the correlation scorer, whose SRAM and search-window address ports it does not touch.

## Interface
- `X_MIN`, default 0: first candidate X (13-bit).
- `X_MAX`, default 16: last allowed candidate X (inclusive).
- `Y_MIN`, default 0: first candidate Y.
- `Y_MAX`, default 16: last allowed candidate Y (inclusive).
- `STEP`, default 1: grid stride in X and Y; must be ≥1.
- `TIMEOUT`, default 65535: maximum cycles spent waiting on one correlation (16-bit).
- `iCLK` in 1: 50 MHz system clock; single clock domain.
- `iRST` in 1: synchronous, active-high reset.
- `iStart` in 1: one-cycle request to begin a search; honoured only in IDLE.
- `oBusy` out 1: high from the cycle after an accepted `iStart` until DONE is left.
- `oDone` out 1: one-cycle pulse when a search ends, whether normal or timeout.
- `oError` out 1: set on timeout; cleared by the next accepted `iStart` or by reset.
- `oXstart`, `oYstart` out 13: candidate coordinates driven to the scorer.
- `oCorrStart` out 1: one-cycle launch pulse to the scorer.
- `iCorrFinished` in 1: scorer finished flag (level).
- `iScore` in 32: scorer result.
- `oBestX`, `oBestY` out 13: coordinates of the best score.
- `oBestScore` out 32: best score found.
- `oCount` out 16: number of candidates scored in the current or last search.

## Operation
- States: IDLE → LAUNCH → WAIT_ACK → WAIT_DONE → SETTLE → COMPARE → ADVANCE → (LAUNCH | DONE) → IDLE.
- **IDLE**
  - On `iStart`: load `oXstart=X_MIN`, `oYstart=Y_MIN`; clear `oBestScore`, `oBestX`, `oBestY`, `oCount` and `oError`; go to LAUNCH.
- **LAUNCH**
  - Assert `oCorrStart` for exactly one cycle; clear the timeout counter; go to WAIT_ACK.
- **WAIT_ACK**
  - Wait for `iCorrFinished==0` (scorer has restarted), then go to WAIT_DONE.
- **WAIT_DONE**
  - Wait for `iCorrFinished==1`, then go to SETTLE.
- **SETTLE**
  - One cycle spent waiting for the scorer's registered score to update; go to COMPARE.
- **COMPARE**
  - Capture `iScore`.
  - If `oCount==0` or `iScore > oBestScore` (strict, unsigned): update the best score and coordinates. On a tie, the earliest candidate in raster order wins.
  - Increment `oCount`, saturating at 0xFFFF; go to ADVANCE.
- **ADVANCE**
  - Raster order, X fastest.
  - If `oXstart+STEP ≤ X_MAX`: X advances by STEP.
  - Else if `oYstart+STEP ≤ Y_MAX`: X returns to X_MIN and Y advances by STEP.
  - Else: go to DONE.
  - Additions are done at 14 bits so that X_MAX or Y_MAX near 8191 cannot wrap.
- **Timeout**
  - The counter runs in WAIT_ACK and WAIT_DONE.
  - When it reaches TIMEOUT: set `oError`, go to DONE, and leave the best outputs as they stood.
- **DONE**
  - Pulse `oDone`, then return to IDLE.
  - The best outputs, `oCount`, `oXstart` and `oYstart` hold until the next accepted `iStart`.
- `iStart` while busy is ignored, with no queuing.
- If X_MIN > X_MAX or Y_MIN > Y_MAX, the single candidate (X_MIN, Y_MIN) is still scored.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - The reset takes effect on the clock edge where `iRST=1` and overrides every other condition, including mid-search. `oCorrStart` is 0 in the following cycle.
- `iStart` at edge n:
  - State is LAUNCH and `oBusy=1` after edge n.
  - `oCorrStart=1` during cycle n+1.
  - `oXstart` and `oYstart` are valid from cycle n+1 and stable until ADVANCE.
- Per-candidate overhead beyond the scorer's own run time: LAUNCH, SETTLE, COMPARE and ADVANCE, i.e. 4 cycles, plus 1 cycle minimum in each wait state.
- COMPARE to the next LAUNCH takes 2 edges.
- The last COMPARE is followed by ADVANCE and then DONE. `oDone` is high for one cycle, and `oBusy` falls in the same cycle that `oDone` falls.
- Best outputs change only at the edge leaving COMPARE.

## Test plan
- X 0..2, Y 0..1, STEP 1, with the scorer model returning 100·(x+1)+y → 6 launches in raster order, `oCount=6`, best (2,1) with score 301, exactly one `oDone` pulse, `oError=0`.
- Same window with all scores 500 → best stays at (0,0) with 500 (tie keeps first).
- X 0..5, STEP 2 → candidates X ∈ {0,2,4}; the value 6 is never driven.
- Scorer held with `iCorrFinished=0`, TIMEOUT=20 → `oError=1` and `oDone` pulse 21 cycles after LAUNCH, followed by IDLE; the next `iStart` clears `oError`.
- `iRST` asserted during the third WAIT_DONE → all outputs 0 the next cycle; a new `iStart` restarts the search from (X_MIN, Y_MIN).
- `iStart` pulsed while busy → no effect: launch sequence unchanged, `oCount` unchanged.

Source files
------------

// File: rtl/corr_search_ctrl.sv
// Correlation search sequencer: walks a raster grid of candidate start positions,
// launches the scorer once per candidate and keeps the highest-scoring position.
module corr_search_ctrl #(
  parameter logic [12:0] X_MIN   = 13'd0,
  parameter logic [12:0] X_MAX   = 13'd16,
  parameter logic [12:0] Y_MIN   = 13'd0,
  parameter logic [12:0] Y_MAX   = 13'd16,
  parameter logic [12:0] STEP    = 13'd1,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  output logic        oBusy,
  output logic        oDone,
  output logic        oError,
  output logic [12:0] oXstart,
  output logic [12:0] oYstart,
  output logic        oCorrStart,
  input  logic        iCorrFinished,
  input  logic [31:0] iScore,
  output logic [12:0] oBestX,
  output logic [12:0] oBestY,
  output logic [31:0] oBestScore,
  output logic [15:0] oCount,
  output logic [2:0]  oState
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_ACK, S_WAIT_DONE,
    S_SETTLE, S_COMPARE, S_ADVANCE, S_DONE
  } state_t;

  // An inverted window still scores the single candidate (X_MIN, Y_MIN).
  localparam logic SINGLE = (X_MIN > X_MAX) || (Y_MIN > Y_MAX);

  state_t      r_state;
  state_t      w_next;
  logic [12:0] r_x;
  logic [12:0] r_y;
  logic [12:0] r_best_x;
  logic [12:0] r_best_y;
  logic [31:0] r_best_score;
  logic [15:0] r_count;
  logic [15:0] r_tmo;
  logic        r_error;

  logic [13:0] w_x_next;
  logic [13:0] w_y_next;
  logic        w_x_fits;
  logic        w_y_fits;
  logic        w_tmo_hit;
  logic        w_better;

  assign w_x_next  = {1'b0, r_x} + {1'b0, STEP};
  assign w_y_next  = {1'b0, r_y} + {1'b0, STEP};
  assign w_x_fits  = !SINGLE && (w_x_next <= {1'b0, X_MAX});
  assign w_y_fits  = !SINGLE && (w_y_next <= {1'b0, Y_MAX});
  assign w_tmo_hit = ({1'b0, r_tmo} + 17'd1) >= {1'b0, TIMEOUT};
  assign w_better  = (r_count == 16'd0) || (iScore > r_best_score);

  // Scorer handshake: oCorrStart is a one-cycle launch; iCorrFinished must first
  // drop (scorer restarted) and then rise (result ready); iScore is read two
  // cycles after the rise so the scorer's registered result has settled.
  always_comb begin
    w_next     = r_state;
    oBusy      = (r_state != S_IDLE);
    oDone      = (r_state == S_DONE);
    oCorrStart = (r_state == S_LAUNCH);
    case (r_state)
      S_IDLE:      if (iStart) w_next = S_LAUNCH;
      S_LAUNCH:    w_next = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (w_tmo_hit)           w_next = S_DONE;
        else if (!iCorrFinished) w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_tmo_hit)          w_next = S_DONE;
        else if (iCorrFinished) w_next = S_SETTLE;
      end
      S_SETTLE:    w_next = S_COMPARE;
      S_COMPARE:   w_next = S_ADVANCE;
      S_ADVANCE:   w_next = (w_x_fits || w_y_fits) ? S_LAUNCH : S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_best_x     <= '0;
      r_best_y     <= '0;
      r_best_score <= '0;
      r_count      <= '0;
      r_tmo        <= '0;
      r_error      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_x          <= X_MIN;
            r_y          <= Y_MIN;
            r_best_x     <= '0;
            r_best_y     <= '0;
            r_best_score <= '0;
            r_count      <= '0;
            r_error      <= 1'b0;
          end
        end
        S_LAUNCH: r_tmo <= '0;
        S_WAIT_ACK, S_WAIT_DONE: begin
          r_tmo <= r_tmo + 16'd1;
          if (w_tmo_hit) r_error <= 1'b1;
        end
        S_COMPARE: begin
          // Strict compare: on a tie the earlier raster candidate stays best.
          if (w_better) begin
            r_best_score <= iScore;
            r_best_x     <= r_x;
            r_best_y     <= r_y;
          end
          if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
        end
        S_ADVANCE: begin
          if (w_x_fits) begin
            r_x <= w_x_next[12:0];
          end else if (w_y_fits) begin
            r_x <= X_MIN;
            r_y <= w_y_next[12:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign oError     = r_error;
  assign oXstart    = r_x;
  assign oYstart    = r_y;
  assign oBestX     = r_best_x;
  assign oBestY     = r_best_y;
  assign oBestScore = r_best_score;
  assign oCount     = r_count;
  assign oState     = r_state;

endmodule

// File: tb/tb_corr_search_ctrl.sv
// Bench for corr_search_ctrl: two instances (dense and strided grids) driven by a
// behavioural scorer, with grid order and best-score expectations derived from a reference model.
module tb_corr_search_ctrl;

  logic clk;
  logic rst;
  logic [1:0]       start, busy, done, err, corr_start, fin;
  logic [1:0][12:0] xs, ys, bx, by;
  logic [1:0][31:0] score, bs;
  logic [1:0][15:0] cnt;
  logic [1:0][2:0]  st;

  typedef struct {
    logic [12:0] x;
    logic [12:0] y;
    logic [31:0] s;
  } ent_t;

  int n_tests, n_fail;
  int mode[2];
  int fix_lat;
  int done_cnt[2];
  int ph[2], cw[2], lt[2];
  logic [31:0] pend[2];
  bit saw_x6;
  ent_t log0[$], log1[$];
  logic [25:0] exp_q[$];

  corr_search_ctrl #(.X_MIN(13'd0), .X_MAX(13'd2), .Y_MIN(13'd0), .Y_MAX(13'd1),
                     .STEP(13'd1), .TIMEOUT(16'd20)) dut0 (
    .iCLK(clk), .iRST(rst), .iStart(start[0]), .oBusy(busy[0]), .oDone(done[0]),
    .oError(err[0]), .oXstart(xs[0]), .oYstart(ys[0]), .oCorrStart(corr_start[0]),
    .iCorrFinished(fin[0]), .iScore(score[0]), .oBestX(bx[0]), .oBestY(by[0]),
    .oBestScore(bs[0]), .oCount(cnt[0]), .oState(st[0]));

  corr_search_ctrl #(.X_MIN(13'd0), .X_MAX(13'd5), .Y_MIN(13'd0), .Y_MAX(13'd2),
                     .STEP(13'd2), .TIMEOUT(16'd100)) dut1 (
    .iCLK(clk), .iRST(rst), .iStart(start[1]), .oBusy(busy[1]), .oDone(done[1]),
    .oError(err[1]), .oXstart(xs[1]), .oYstart(ys[1]), .oCorrStart(corr_start[1]),
    .iCorrFinished(fin[1]), .iScore(score[1]), .oBestX(bx[1]), .oBestY(by[1]),
    .oBestScore(bs[1]), .oCount(cnt[1]), .oState(st[1]));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural scorer ----------------
  function automatic logic [31:0] score_of(input int md, input logic [12:0] x, input logic [12:0] y);
    logic [31:0] r;
    case (md)
      0: return 32'd100 * ({19'd0, x} + 32'd1) + {19'd0, y};
      1: return 32'd500;
      default: begin
        r = $urandom_range(0, 7);
        return (r << 29) | $urandom_range(0, 1);
      end
    endcase
  endfunction

  task automatic scorer_step(input int k);
    ent_t e;
    if (rst) begin
      ph[k]  = 0;
      fin[k] = 1'b1;
      return;
    end
    if (done[k]) done_cnt[k]++;
    if (k == 1 && xs[1] > 13'd5) saw_x6 = 1'b1;
    if (corr_start[k]) begin
      e.x = xs[k];
      e.y = ys[k];
      e.s = score_of(mode[k], xs[k], ys[k]);
      if (k == 0) log0.push_back(e);
      else        log1.push_back(e);
      pend[k] = e.s;
      if (fix_lat != 0) begin
        cw[k] = 0;
        lt[k] = fix_lat;
      end else begin
        cw[k] = $urandom_range(0, 2);
        lt[k] = $urandom_range(1, 6);
      end
      ph[k] = 1;
    end else if (ph[k] == 1) begin
      if (cw[k] == 0) begin
        fin[k] = 1'b0;
        ph[k]  = 2;
        cw[k]  = lt[k];
      end else cw[k]--;
    end else if (ph[k] == 2 && mode[k] != 3) begin
      if (cw[k] == 0) begin
        score[k] = pend[k];
        fin[k]   = 1'b1;
        ph[k]    = 0;
      end else cw[k]--;
    end
  endtask

  initial begin
    fin = '1;
    score = '0;
    saw_x6 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      done_cnt[k] = 0;
      ph[k] = 0;
      cw[k] = 0;
      lt[k] = 0;
      pend[k] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) scorer_step(k);
    end
  end

  // ---------------- reference model ----------------
  function automatic void build_exp(input int k);
    int xmin, xmax, ymin, ymax, stp;
    exp_q.delete();
    if (k == 0) begin xmin = 0; xmax = 2; ymin = 0; ymax = 2 - 1; stp = 1; end
    else        begin xmin = 0; xmax = 5; ymin = 0; ymax = 2;     stp = 2; end
    for (int y = ymin; y <= ymax; y += stp)
      for (int x = xmin; x <= xmax; x += stp)
        exp_q.push_back({13'(x), 13'(y)});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    step();
    start[k] = 1'b0;
  endtask

  task automatic check_zero(input int k);
    check("rst_busy", busy[k], 0);
    check("rst_done", done[k], 0);
    check("rst_err", err[k], 0);
    check("rst_corr_start", corr_start[k], 0);
    check("rst_x", xs[k], 0);
    check("rst_y", ys[k], 0);
    check("rst_best_x", bx[k], 0);
    check("rst_best_y", by[k], 0);
    check("rst_best_score", bs[k], 0);
    check("rst_count", cnt[k], 0);
  endtask

  task automatic run_search(input int k, input int md, input bit noise);
    int base, nlog, d0, steps, bi;
    bit got;
    ent_t e;
    logic [31:0] bsv;
    mode[k] = md;
    build_exp(k);
    base = (k == 0) ? log0.size() : log1.size();
    d0 = done_cnt[k];
    pulse_start(k);
    check("launch_busy", busy[k], 1);
    check("launch_pulse", corr_start[k], 1);
    check("launch_err_clear", err[k], 0);
    check("launch_x", xs[k], exp_q[0][25:13]);
    check("launch_y", ys[k], exp_q[0][12:0]);
    got = 1'b0;
    steps = 0;
    while (!got && steps < 2000) begin
      start[k] = noise && ($urandom_range(0, 3) == 0);
      step();
      steps++;
      got = done[k];
    end
    start[k] = 1'b0;
    check("done_seen", got, 1);
    check("done_busy", busy[k], 1);
    if (noise) start[k] = 1'b1;
    step();
    start[k] = 1'b0;
    check("done_one_cycle", done[k], 0);
    check("idle_busy", busy[k], 0);
    check("done_pulses", done_cnt[k] - d0, 1);
    check("err_normal", err[k], 0);
    nlog = ((k == 0) ? log0.size() : log1.size()) - base;
    check("launch_count", nlog, exp_q.size());
    check("count", cnt[k], exp_q.size());
    bi = 0;
    bsv = '0;
    for (int i = 0; i < nlog && i < exp_q.size(); i++) begin
      e = (k == 0) ? log0[base + i] : log1[base + i];
      check("order_x", e.x, exp_q[i][25:13]);
      check("order_y", e.y, exp_q[i][12:0]);
      if (i == 0 || e.s > bsv) begin
        bsv = e.s;
        bi = i;
      end
    end
    check("best_score", bs[k], bsv);
    check("best_x", bx[k], exp_q[bi][25:13]);
    check("best_y", by[k], exp_q[bi][12:0]);
    check("hold_x", xs[k], exp_q[exp_q.size() - 1][25:13]);
    check("hold_y", ys[k], exp_q[exp_q.size() - 1][12:0]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0, steps, base;
    bit got;
    n_tests = 0;
    n_fail = 0;
    start = '0;
    rst = 1'b1;
    mode[0] = 0;
    mode[1] = 0;
    fix_lat = 0;
    repeat (3) step();
    check_zero(0);
    check_zero(1);
    rst = 1'b0;
    step();

    // Graded scores: best is the last candidate (2,1) with 301.
    run_search(0, 0, 1'b0);
    check("graded_best_x", bx[0], 2);
    check("graded_best_y", by[0], 1);
    check("graded_best_score", bs[0], 301);
    check("graded_count", cnt[0], 6);

    // All scores equal: first candidate keeps the lead.
    run_search(0, 1, 1'b0);
    check("tie_best_x", bx[0], 0);
    check("tie_best_y", by[0], 0);
    check("tie_best_score", bs[0], 500);

    // Strided grid: X in {0,2,4}, Y in {0,2}.
    run_search(1, 0, 1'b0);
    check("stride_best_x", bx[1], 4);
    check("stride_best_y", by[1], 2);
    check("stride_best_score", bs[1], 502);
    check("stride_no_x6", saw_x6, 0);

    for (int r = 0; r < 4; r++) begin
      run_search(0, 2, 1'b0);
      run_search(1, 2, 1'b0);
    end

    // iStart pulses while busy (including during DONE) change nothing.
    run_search(0, 0, 1'b1);
    check("noise_count", cnt[0], 6);

    // Timeout: scorer drops finished and never raises it.
    mode[0] = 3;
    d0 = done_cnt[0];
    pulse_start(0);
    got = 1'b0;
    steps = 0;
    while (!got && steps < 200) begin
      step();
      steps++;
      got = done[0];
    end
    check("tmo_seen", got, 1);
    check("tmo_latency", steps, 21);
    check("tmo_err", err[0], 1);
    check("tmo_count", cnt[0], 0);
    check("tmo_best_score", bs[0], 0);
    step();
    check("tmo_idle", busy[0], 0);
    check("tmo_err_hold", err[0], 1);
    check("tmo_pulses", done_cnt[0] - d0, 1);
    run_search(0, 0, 1'b0);

    // Reset during the third WAIT_DONE.
    mode[0] = 0;
    fix_lat = 8;
    base = log0.size();
    pulse_start(0);
    steps = 0;
    while (log0.size() - base < 3 && steps < 300) begin
      step();
      steps++;
    end
    check("rst_reach_third", log0.size() - base, 3);
    repeat (4) step();
    rst = 1'b1;
    step();
    check_zero(0);
    rst = 1'b0;
    fix_lat = 0;
    step();
    run_search(0, 0, 1'b0);
    check("post_rst_best_score", bs[0], 301);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
